uart_rx_core: RTL and testbench

Receive-side shift engine of the UART: oversamples the serial line with the shared 16x baud tick, deserialises 5-8 data bits LSB-first, checks optional parity and the stop bit, and pushes each received character into the receive FIFO (RBR). It consumes the transmitter's `tx_out` in loopback and the same `btick` produced by the baud tick generator, so it mirrors the transmit shift register stage on the receive path.

---
 rtl/uart_rx_core.sv | 118 +++++++++++
 tb/tb_uart_rx_core.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// uart_rx_core: 16x-oversampled UART receive engine, 5-8 data bits LSB-first, optional parity, one stop bit.
// Define UART_RX_PARITY_EN to build the PARITY state and checker; otherwise parity_err is tied low.
module uart_rx_core (
    input  logic       clk,
    input  logic       rst,
    input  logic       btick,
    input  logic       rx_in,
    input  logic [1:0] rlen,
    input  logic       parity_en,
    input  logic       parity_type,
    input  logic       fifo_full,
    output logic       wr_en,
    output logic [7:0] rdata,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun,
    output logic       busy
);
`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
    state_t     r_state, w_next;
    logic       r_sync, r_rxs, r_rxs_d;
    logic [3:0] r_tcnt;
    logic [2:0] r_bcnt;
    logic [7:0] r_shift;
    logic [1:0] r_rlen;
    logic       r_perr;
    logic       w_fall, w_mid;
    logic [2:0] w_last;
`ifdef UART_RX_PARITY_EN
    logic       r_pen, r_ptype;
`else
    logic       w_unused;
    assign w_unused = &{1'b0, parity_en, parity_type};
`endif
    assign w_fall = r_rxs_d & ~r_rxs;
    assign w_mid  = btick && r_tcnt == 4'd15;
    assign w_last = 3'd4 + {1'b0, r_rlen};
    assign busy   = r_state != IDLE;
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_fall) w_next = START;
            START:   if (btick && r_tcnt == 4'd7) w_next = r_rxs ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
            DATA:    if (w_mid && r_bcnt == w_last) w_next = r_pen ? PARITY : STOP;
            PARITY:  if (w_mid) w_next = STOP;
`else
            DATA:    if (w_mid && r_bcnt == w_last) w_next = STOP;
`endif
            STOP:    if (w_mid) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync     <= 1'b1;
            r_rxs      <= 1'b1;
            r_rxs_d    <= 1'b1;
            r_tcnt     <= 4'd0;
            r_bcnt     <= 3'd0;
            r_shift    <= 8'h00;
            r_rlen     <= 2'd0;
            r_perr     <= 1'b0;
            wr_en      <= 1'b0;
            rdata      <= 8'h00;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_pen      <= 1'b0;
            r_ptype    <= 1'b0;
`endif
        end else begin
            r_sync     <= rx_in;
            r_rxs      <= r_sync;
            r_rxs_d    <= r_rxs;
            // A btick landing on the entry cycle is deliberately dropped.
            r_tcnt     <= (w_next != r_state) ? 4'd0 : r_tcnt + {3'd0, btick};
            wr_en      <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
            if (r_state == IDLE && w_fall) begin
                r_rlen  <= rlen;
                r_shift <= 8'h00;
                r_bcnt  <= 3'd0;
                r_perr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                r_pen   <= parity_en;
                r_ptype <= parity_type;
`endif
            end
            if (r_state == DATA && w_mid) begin
                r_shift <= {r_rxs, r_shift[7:1]};
                r_bcnt  <= r_bcnt + 3'd1;
            end
`ifdef UART_RX_PARITY_EN
            // Shift register was cleared at start, so its XOR covers exactly the data bits.
            if (r_state == PARITY && w_mid) r_perr <= (^{r_shift, r_rxs}) != r_ptype;
`endif
            if (r_state == STOP && w_mid) begin
                rdata      <= r_shift >> (2'd3 - r_rlen);
                wr_en      <= ~fifo_full;
                overrun    <= fifo_full;
                frame_err  <= ~r_rxs;
                parity_err <= r_perr;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed frames against uart_rx_core with hand-computed expectations.
module tb_uart_rx_core;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btick = 1'b0;
    logic       rx_in = 1'b1;
    logic [1:0] rlen = 2'd3;
    logic       parity_en = 1'b0;
    logic       parity_type = 1'b0;
    logic       fifo_full = 1'b0;
    logic       wr_en, frame_err, parity_err, overrun, busy;
    logic [7:0] rdata;
    int n_checks = 0, n_errs = 0;
    int n_wr = 0, n_fe = 0, n_pe = 0, n_ov = 0, n_busywr = 0, bc = 0;
    int w0, f0, p0, o0;
    logic [7:0] last_rd = 8'h00;
    logic [7:0] wr_q[$];

    uart_rx_core dut (
        .clk(clk), .rst(rst), .btick(btick), .rx_in(rx_in), .rlen(rlen),
        .parity_en(parity_en), .parity_type(parity_type), .fifo_full(fifo_full),
        .wr_en(wr_en), .rdata(rdata), .frame_err(frame_err), .parity_err(parity_err),
        .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        bc = (bc + 1) % 16;
        btick = (bc == 0);
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en) begin
                n_wr++;
                wr_q.push_back(rdata);
                last_rd = rdata;
                if (busy) n_busywr++;
            end
            if (overrun) begin
                n_ov++;
                last_rd = rdata;
            end
            if (frame_err) n_fe++;
            if (parity_err) n_pe++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic bit_time();
        repeat (256) @(negedge clk);
    endtask

    task automatic snap();
        w0 = n_wr; f0 = n_fe; p0 = n_pe; o0 = n_ov;
        wr_q.delete();
    endtask

    task automatic send_frame(input logic [7:0] d, input int n, input int par, input logic stop);
        rx_in = 1'b0;
        bit_time();
        for (int i = 0; i < n; i++) begin
            rx_in = d[i];
            bit_time();
        end
        if (par >= 0) begin
            rx_in = par[0];
            bit_time();
        end
        rx_in = stop;
        bit_time();
        rx_in = 1'b1;
    endtask

    task automatic expect_frame(input string tag, input int wr, input logic [7:0] rd,
                                input int fe, input int pe, input int ov);
        check({tag, "_wr"}, n_wr - w0, wr);
        check({tag, "_rdata"}, last_rd, rd);
        check({tag, "_ferr"}, n_fe - f0, fe);
        check({tag, "_perr"}, n_pe - p0, pe);
        check({tag, "_ovr"}, n_ov - o0, ov);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        repeat (4) @(negedge clk);
        check("rst_out", {wr_en, frame_err, parity_err, overrun, busy, rdata}, 0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("idle_out", {wr_en, frame_err, parity_err, overrun, busy, rdata}, 0);

        snap();
        send_frame(8'hA5, 8, -1, 1'b1);
        bit_time();
        expect_frame("a5", 1, 8'hA5, 0, 0, 0);
        check("wr_while_busy", n_busywr, 0);

        rlen = 2'd0;
        snap();
        send_frame(8'h1F, 5, -1, 1'b1);
        send_frame(8'h0A, 5, -1, 1'b1);
        bit_time();
        check("b2b_wr", n_wr - w0, 2);
        check("b2b_first", wr_q.size() > 0 ? wr_q[0] : 8'hxx, 8'h1F);
        check("b2b_second", wr_q.size() > 1 ? wr_q[1] : 8'hxx, 8'h0A);

        rlen = 2'd2; parity_en = 1'b1; parity_type = 1'b0;
        snap();
        send_frame(8'h41, 7, 1, 1'b1);
        bit_time();
`ifdef UART_RX_PARITY_EN
        expect_frame("par_bad", 1, 8'h41, 0, 1, 0);
`else
        expect_frame("par_bad", 1, 8'h41, 0, 0, 0);
`endif
        snap();
        send_frame(8'h41, 7, 0, 1'b1);
        bit_time();
`ifdef UART_RX_PARITY_EN
        expect_frame("par_ok", 1, 8'h41, 0, 0, 0);
`else
        expect_frame("par_ok", 1, 8'h41, 1, 0, 0);
`endif
        rlen = 2'd3; parity_en = 1'b0;

        snap();
        send_frame(8'h3C, 8, -1, 1'b0);
        bit_time();
        expect_frame("stop0", 1, 8'h3C, 1, 0, 0);

        snap();
        rx_in = 1'b0;
        repeat (2) @(negedge clk);
        check("edge_lat2", busy, 0);
        @(negedge clk);
        check("edge_lat3", busy, 1);
        repeat (61) @(negedge clk);
        rx_in = 1'b1;
        bit_time();
        check("glitch_wr", n_wr - w0, 0);
        check("glitch_busy", busy, 0);

        fifo_full = 1'b1;
        snap();
        send_frame(8'h55, 8, -1, 1'b1);
        bit_time();
        expect_frame("full", 0, 8'h55, 0, 0, 1);
        fifo_full = 1'b0;

        snap();
        rx_in = 1'b0;
        bit_time();
        for (int i = 0; i < 3; i++) begin
            rx_in = i[0];
            bit_time();
        end
        rx_in = 1'b0;
        repeat (100) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        rst = 1'b1; rx_in = 1'b1;
        @(negedge clk);
        check("mid_rst_out", {wr_en, frame_err, parity_err, overrun, busy, rdata}, 0);
        rst = 1'b0;
        repeat (12) bit_time();
        check("mid_rst_nowr", n_wr - w0, 0);
        check("mid_rst_noerr", (n_fe - f0) + (n_ov - o0), 0);
        snap();
        send_frame(8'h81, 8, -1, 1'b1);
        bit_time();
        expect_frame("after_rst", 1, 8'h81, 0, 0, 0);

        snap();
        last_rd = 8'hFF;
        rx_in = 1'b0;
        repeat (14) bit_time();
        check("break_wr", n_wr - w0, 1);
        check("break_rdata", last_rd, 8'h00);
        check("break_ferr", n_fe - f0, 1);
        check("break_idle", busy, 0);
        rx_in = 1'b1;
        bit_time();
        check("break_release", n_wr - w0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end
endmodule
